// File: rtl/cnt_pkg.sv
// Shared definitions for the JK-based counter library: JK cell control
// encodings and the elaboration-time modulus range check.
package cnt_pkg;

  // {J,K} control pair applied to a JK cell.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_op_e;

  // A count sequence 0..modulus-1 must have at least two states and
  // must fit in the available width.
  function automatic bit modulus_ok(input int unsigned width,
                                    input int unsigned modulus);
    return (modulus >= 32'd2) && (modulus <= (32'd1 << width));
  endfunction

  function automatic bit width_ok(input int unsigned width);
    return (width >= 32'd1) && (width <= 32'd16);
  endfunction

endpackage

// File: rtl/jk_ff_ar.sv
// Single JK flip-flop cell with asynchronous active-low reset to 0.
module jk_ff_ar
  import cnt_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  // JK truth table: hold, reset, set or toggle on each rising edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= 1'b0;
    end else begin
      case (jk_op_e'({j_i, k_i}))
        JK_HOLD: q_q <= q_q;
        JK_RST:  q_q <= 1'b0;
        JK_SET:  q_q <= 1'b1;
        JK_TOG:  q_q <= ~q_q;
      endcase
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk_sync_up_counter.sv
// Synchronous modulo-N up counter built from JK cells, with enable,
// synchronous clear, parallel load, terminal count and registered wrap pulse.
module jk_sync_up_counter
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("jk_sync_up_counter: WIDTH must be 1..16");
  end

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("jk_sync_up_counter: MODULUS must be 2..2**WIDTH");
  end

  // Terminal value compared in WIDTH+1 bits so MODULUS = 2**WIDTH fits.
  localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(MODULUS - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             at_last;
  logic             wrap_q;
  logic             wrap_d;

  // Values >= LAST (including out-of-range loaded values) wrap next.
  assign at_last = {1'b0, q_q} >= LAST;

  // Select next count with priority clr > load > en > hold.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = d;
    end else if (en) begin
      if (at_last) begin
        q_d    = '0;
        wrap_d = 1'b1;
      end else begin
        q_d = WIDTH'({1'b0, q_q} + (WIDTH + 1)'(1));
      end
    end
  end

  // Generic JK excitation: set bits that must rise, reset bits that must fall.
  assign j = q_d & ~q_q;
  assign k = ~q_d & q_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_ff_ar u_cell (
      .clk_i  (clk),
      .rst_ni (rst),
      .j_i    (j[i]),
      .k_i    (k[i]),
      .q_o    (q_q[i])
    );
  end

  // One-cycle wrap pulse registered after the wrapping edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign tc   = en & at_last;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_sync_up_counter.sv
module tb_jk_sync_up_counter;

  localparam int unsigned NI = 5;
  // instance 0: W4 M16, 1: W4 M10, 2: W1 M2, 3/4: cascade W4 M10
  localparam int MODS [NI] = '{16, 10, 2, 10, 10};

  typedef struct {
    logic [3:0] q;
    logic       tc;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, clr, load;
  logic [3:0] d;
  logic       cen, cclr;

  logic [3:0] q_bin, q_dec, q_c0, q_c1;
  logic [0:0] q_m2;
  logic       tc_bin, tc_dec, tc_m2, tc_c0, tc_c1;
  logic       wr_bin, wr_dec, wr_m2, wr_c0, wr_c1;

  logic [3:0] aq  [NI];
  logic       atc [NI];
  logic       awr [NI];

  exp_t sbq [NI][$];
  int   mq  [NI];
  bit   mw  [NI];

  int checks   = 0;
  int failures = 0;
  bit mon_on   = 1'b0;
  int c0_wraps = 0;
  int c1_wraps = 0;

  always #5 clk = ~clk;

  jk_sync_up_counter #(.WIDTH(4), .MODULUS(16)) u_bin (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .d(d),
    .q(q_bin), .tc(tc_bin), .wrap(wr_bin));

  jk_sync_up_counter #(.WIDTH(4), .MODULUS(10)) u_dec (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .d(d),
    .q(q_dec), .tc(tc_dec), .wrap(wr_dec));

  jk_sync_up_counter #(.WIDTH(1), .MODULUS(2)) u_m2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .d(d[0:0]),
    .q(q_m2), .tc(tc_m2), .wrap(wr_m2));

  jk_sync_up_counter #(.WIDTH(4), .MODULUS(10)) u_c0 (
    .clk(clk), .rst(rst), .en(cen), .clr(cclr), .load(1'b0), .d(4'd0),
    .q(q_c0), .tc(tc_c0), .wrap(wr_c0));

  jk_sync_up_counter #(.WIDTH(4), .MODULUS(10)) u_c1 (
    .clk(clk), .rst(rst), .en(tc_c0), .clr(cclr), .load(1'b0), .d(4'd0),
    .q(q_c1), .tc(tc_c1), .wrap(wr_c1));

  assign aq[0] = q_bin;            assign atc[0] = tc_bin; assign awr[0] = wr_bin;
  assign aq[1] = q_dec;            assign atc[1] = tc_dec; assign awr[1] = wr_dec;
  assign aq[2] = {3'b000, q_m2};   assign atc[2] = tc_m2;  assign awr[2] = wr_m2;
  assign aq[3] = q_c0;             assign atc[3] = tc_c0;  assign awr[3] = wr_c0;
  assign aq[4] = q_c1;             assign atc[4] = tc_c1;  assign awr[4] = wr_c1;

  // Reference behaviour of one counter for one edge.
  function automatic void step(input int m, input int qc, input bit c,
                               input bit l, input bit e, input int dv,
                               output int qn, output bit wn);
    wn = 1'b0;
    if (c)              qn = 0;
    else if (l)         qn = dv;
    else if (e) begin
      if (qc >= m - 1) begin qn = 0; wn = 1'b1; end
      else             qn = qc + 1;
    end else            qn = qc;
  endfunction

  function automatic void push_all(input bit e, input bit ce);
    bit   ens [NI];
    exp_t x;
    ens[0] = e; ens[1] = e; ens[2] = e; ens[3] = ce;
    ens[4] = ce && (mq[3] >= MODS[3] - 1);
    for (int unsigned k = 0; k < NI; k++) begin
      x.q    = 4'(mq[k]);
      x.tc   = ens[k] && (mq[k] >= MODS[k] - 1);
      x.wrap = mw[k];
      sbq[k].push_back(x);
    end
  endfunction

  // Drive one cycle of stimulus at the falling edge and queue the response
  // expected after the following rising edge.
  task automatic cycle(input bit r, input bit e, input bit c, input bit l,
                       input logic [3:0] dv, input bit ce, input bit cc);
    int qn;
    bit wn;
    bit c1en;
    @(negedge clk);
    rst = r; en = e; clr = c; load = l; d = dv; cen = ce; cclr = cc;
    if (!r) begin
      for (int unsigned k = 0; k < NI; k++) begin mq[k] = 0; mw[k] = 1'b0; end
    end else begin
      c1en = ce && (mq[3] >= MODS[3] - 1);
      step(MODS[0], mq[0], c, l, e, int'(dv), qn, wn);      mq[0] = qn; mw[0] = wn;
      step(MODS[1], mq[1], c, l, e, int'(dv), qn, wn);      mq[1] = qn; mw[1] = wn;
      step(MODS[2], mq[2], c, l, e, int'(dv) % 2, qn, wn);  mq[2] = qn; mw[2] = wn;
      step(MODS[3], mq[3], cc, 1'b0, ce, 0, qn, wn);        mq[3] = qn; mw[3] = wn;
      step(MODS[4], mq[4], cc, 1'b0, c1en, 0, qn, wn);      mq[4] = qn; mw[4] = wn;
    end
    push_all(e, ce);
    mon_on = 1'b1;
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic drop_rst();
    @(posedge clk);
    #3;
    for (int unsigned k = 0; k < NI; k++) begin mq[k] = 0; mw[k] = 1'b0; end
    push_all(en, cen);
    rst = 1'b0;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      if (mon_on) begin
        #1;
        for (int unsigned k = 0; k < NI; k++) begin
          if (sbq[k].size() == 0) begin
            checks++; failures++;
            $display("FAIL underrun inst%0d: no expectation queued at %0t", k, $time);
          end else begin
            e = sbq[k].pop_front();
            checks++;
            if (aq[k] !== e.q) begin
              failures++;
              $display("FAIL q inst%0d @%0t: got %0d expected %0d", k, $time, aq[k], e.q);
            end
            checks++;
            if (atc[k] !== e.tc) begin
              failures++;
              $display("FAIL tc inst%0d @%0t: got %b expected %b", k, $time, atc[k], e.tc);
            end
            checks++;
            if (awr[k] !== e.wrap) begin
              failures++;
              $display("FAIL wrap inst%0d @%0t: got %b expected %b", k, $time, awr[k], e.wrap);
            end
          end
        end
        if (awr[3] === 1'b1) c0_wraps++;
        if (awr[4] === 1'b1) c1_wraps++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] dv;
    rst = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; d = '0; cen = 1'b0; cclr = 1'b0;
    for (int unsigned k = 0; k < NI; k++) begin mq[k] = 0; mw[k] = 1'b0; end

    // reset state, then count to 9 and reset mid-count
    cycle(0, 0, 0, 0, 4'd0, 0, 0);
    cycle(0, 1, 0, 0, 4'd0, 0, 0);
    for (int unsigned i = 0; i < 9; i++) cycle(1, 1, 0, 0, 4'd0, 0, 0);
    drop_rst();
    cycle(0, 1, 0, 0, 4'd0, 0, 0);
    for (int unsigned i = 0; i < 3; i++) cycle(1, 1, 0, 0, 4'd0, 0, 0);

    // full binary wrap from 0
    cycle(1, 0, 1, 0, 4'd0, 0, 0);
    for (int unsigned i = 0; i < 17; i++) cycle(1, 1, 0, 0, 4'd0, 0, 0);

    // priority: clr > load > en
    cycle(1, 0, 0, 1, 4'd5, 0, 0);
    cycle(1, 1, 1, 1, 4'd12, 0, 0);
    cycle(1, 1, 0, 1, 4'd12, 0, 0);
    // out-of-range hold then recovery
    cycle(1, 0, 0, 1, 4'd13, 0, 0);
    cycle(1, 0, 0, 0, 4'd0, 0, 0);
    cycle(1, 0, 0, 0, 4'd0, 0, 0);
    cycle(1, 1, 0, 0, 4'd0, 0, 0);
    cycle(1, 0, 0, 0, 4'd0, 0, 0);
    // load with en at terminal count: load wins
    cycle(1, 0, 0, 1, 4'd15, 0, 0);
    cycle(1, 1, 0, 1, 4'd3, 0, 0);
    cycle(1, 0, 0, 0, 4'd0, 0, 0);

    // cascade: 100 enabled edges, 99 -> 00
    cycle(1, 0, 0, 0, 4'd0, 0, 1);
    cycle(1, 0, 0, 0, 4'd0, 0, 0);
    @(posedge clk); #2;
    c0_wraps = 0; c1_wraps = 0;
    for (int unsigned i = 0; i < 100; i++) cycle(1, 0, 0, 0, 4'd0, 1, 0);
    cycle(1, 0, 0, 0, 4'd0, 0, 0);
    cycle(1, 0, 0, 0, 4'd0, 0, 0);
    @(posedge clk); #2;
    check_int("cascade_stage0_wraps", c0_wraps, 10);
    check_int("cascade_stage1_wraps", c1_wraps, 1);

    // randomized traffic
    for (int unsigned i = 0; i < 400; i++) begin
      dv = 4'($urandom_range(0, 15));
      cycle(1, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) == 0, dv,
            $urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0);
    end
    cycle(1, 0, 0, 0, 4'd0, 0, 0);
    @(posedge clk); #3;

    for (int unsigned k = 0; k < NI; k++)
      check_int($sformatf("leftover_inst%0d", k), sbq[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_sync_up_counter.md
# jk_sync_up_counter

Synchronous binary up counter built from JK flip-flop cells. It counts in the opposite direction to the team's JK synchronous down counter and serves as its up-counting companion in the counters library. It adds enable, synchronous clear, parallel load, a programmable modulus, a terminal-count flag and a registered wrap pulse, so it can drive cascaded counter chains and timing generators.

## Interface
- WIDTH, 4, counter width in bits (1..16)
- MODULUS, 2**WIDTH, count sequence is 0..MODULUS-1 (legal range 2..2**WIDTH)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserts immediately, released synchronously to clk by the system)
- en  in  1  count enable; advance by one when high
- clr  in  1  synchronous clear to 0
- load  in  1  synchronous parallel load
- d  in  WIDTH  load value
- q  out  WIDTH  count; q[0] is the LSB
- tc  out  1  terminal count, combinational: en & (q >= MODULUS-1)
- wrap  out  1  registered one-cycle pulse in the cycle after q wraps to 0

## Operation
- Every state bit is one JK cell. Per bit: J = nxt[i] & ~q[i], K = ~nxt[i] & q[i], where nxt is the selected next count.
- For power-of-two MODULUS this reduces to J = K = AND of lower bits; the generic form is mandatory.
- Priority per edge: clr > load > en > hold.
  - clr: nxt = 0, wrap = 0.
  - load: nxt = d; a d >= MODULUS is loaded unchanged and no error is flagged. wrap = 0.
  - en and q >= MODULUS-1: nxt = 0, wrap = 1 next cycle.
  - en otherwise: nxt = q + 1, with width wrap-free arithmetic in WIDTH+1 bits.
  - Neither clr, load nor en: hold; wrap = 0.
- An out-of-range q (reachable only via load) wraps to 0 on the next enabled edge, so the counter self-recovers.
- tc is usable as en for the next stage of a cascade. A chain of such counters counts synchronously with no ripple.

## Timing
- Reset (rst low, any time, including mid-count): q = 0, wrap = 0 immediately. tc = 0 whenever MODULUS > 1 and q = 0.
- First count edge: the first rising clk after rst deasserts with en = 1 gives q = 1.
- Latency:
  - q updates on the same edge as the sampled en, clr or load.
  - tc follows q and en combinationally in the same cycle.
  - wrap is high for exactly the one cycle following the wrapping edge.
- Simultaneous clr and load: clr wins. Simultaneous load and en at terminal count: load wins, wrap = 0.
- A back-to-back wrap (MODULUS = 2 with en held high) gives wrap high every other cycle.

## Structure
- Shared package cnt_pkg holds:
  - the localparam function clog2-free range check for MODULUS (elaboration error if MODULUS < 2 or MODULUS > 2**WIDTH);
  - the JK encoding constants JK_HOLD = 2'b00, JK_RST = 2'b01, JK_SET = 2'b10, JK_TOG = 2'b11.
- Sub-module jk_ff_ar: single JK cell with async active-low reset (q = 0 on reset), JK truth table per cnt_pkg constants. The top level instantiates WIDTH copies through a generate loop, plus one plain flop for wrap.

## Test plan
- Reset mid-count: WIDTH=4, count to 9, drop rst between clock edges -> q = 0 and wrap = 0 immediately. After release with en = 1, q steps 1, 2, 3.
- Full binary wrap: WIDTH=4, MODULUS=16, en held high for 17 edges -> q goes 0..15 then 0. tc high only while q = 15. wrap high for the single cycle after q returns to 0.
- Decade counter: MODULUS=10 -> q sequence 0..9, 0. Bit patterns 10..15 never appear. tc high at q = 9.
- Priority: with q = 5, assert clr, load (d = 12) and en together -> q = 0. Then load with en, d = 12 -> q = 12, wrap = 0.
- Out-of-range recovery: MODULUS=10, load d = 13, then en -> q = 0 on the next edge and wrap pulses once. With en low, q holds at 13 and tc = 0.
- Cascade: two instances (MODULUS=10 each), stage-1 en = stage-0 tc, 100 enabled edges -> count reaches 99 then 00. Stage-1 wrap pulses exactly once.
